// File: rtl/sram_req_arbiter_pkg.sv
// Shared source encodings and access-size codes for the SRAM-like request arbiter.
package sram_req_arbiter_pkg;

  typedef logic src_t;

  localparam src_t SRC_INST = 1'b0;
  localparam src_t SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_src_fifo.sv
// In-order FIFO of 1-bit source tags (module arb_src_fifo) with occupancy count, full and empty.
module arb_src_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_din,
  input  logic                     i_pop,
  output logic                     o_head,
  output logic [$clog2(Depth):0]   o_cnt,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne  = 1;
  localparam logic [PtrW:0]   CntOne  = 1;
  localparam logic [PtrW:0]   CntFull = Depth[PtrW:0];

  logic            r_mem [Depth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [PtrW:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_cnt == CntFull);
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  assign o_head  = r_mem[r_rptr];

  // Guarding here keeps the count saturated at both ends regardless of the caller.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < Depth; i++) r_mem[i] <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + PtrOne;
      end
      if (w_pop) r_rptr <= r_rptr + PtrOne;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntOne;
        2'b01:   r_cnt <= r_cnt - CntOne;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like master port between inst and data requesters, routing responses in order.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of data-first priority.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_inst_req,
  input  logic                         i_inst_wr,
  input  logic [1:0]                   i_inst_size,
  input  logic [DATA_W/8-1:0]          i_inst_wstrb,
  input  logic [ADDR_W-1:0]            i_inst_addr,
  input  logic [DATA_W-1:0]            i_inst_wdata,
  input  logic                         i_inst_uncache,
  output logic                         o_inst_addr_ok,
  output logic                         o_inst_data_ok,
  output logic [DATA_W-1:0]            o_inst_rdata,
  input  logic                         i_data_req,
  input  logic                         i_data_wr,
  input  logic [1:0]                   i_data_size,
  input  logic [DATA_W/8-1:0]          i_data_wstrb,
  input  logic [ADDR_W-1:0]            i_data_addr,
  input  logic [DATA_W-1:0]            i_data_wdata,
  input  logic                         i_data_uncache,
  output logic                         o_data_addr_ok,
  output logic                         o_data_data_ok,
  output logic [DATA_W-1:0]            o_data_rdata,
  output logic                         o_m_req,
  output logic                         o_m_wr,
  output logic [1:0]                   o_m_size,
  output logic [DATA_W/8-1:0]          o_m_wstrb,
  output logic [ADDR_W-1:0]            o_m_addr,
  output logic [DATA_W-1:0]            o_m_wdata,
  output logic                         o_m_uncache,
  input  logic                         i_m_addr_ok,
  input  logic                         i_m_data_ok,
  input  logic [DATA_W-1:0]            i_m_rdata,
  output logic [$clog2(MAX_OUTST):0]   o_outst_cnt,
  output logic                         o_err_spurious
);

  logic                       r_lock;
  src_t                       r_lock_src;
  logic                       r_err;
  src_t                       w_grant;
  src_t                       w_tie_src;
  logic                       w_sel_req;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_head;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(MAX_OUTST):0] w_cnt;

`ifdef ARB_ROUND_ROBIN_EN
  src_t r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_last <= SRC_INST;
    else if (w_push) r_last <= w_grant;
  end

  assign w_tie_src = ~r_last;
`else
  assign w_tie_src = SRC_DATA;
`endif

  always_comb begin
    w_grant = SRC_INST;
    if (r_lock)                        w_grant = r_lock_src;
    else if (i_inst_req && i_data_req) w_grant = w_tie_src;
    else if (i_data_req)               w_grant = SRC_DATA;
  end

  assign w_sel_req = (w_grant == SRC_DATA) ? i_data_req : i_inst_req;
  // Full blocks issue even when a pop lands in the same cycle: no bypass path.
  assign o_m_req   = ~i_rst & ~w_full & w_sel_req;
  assign w_push    = o_m_req & i_m_addr_ok;
  assign w_pop     = ~i_rst & i_m_data_ok & ~w_empty;

  assign o_m_wr      = (w_grant == SRC_DATA) ? i_data_wr      : i_inst_wr;
  assign o_m_size    = (w_grant == SRC_DATA) ? i_data_size    : i_inst_size;
  assign o_m_wstrb   = (w_grant == SRC_DATA) ? i_data_wstrb   : i_inst_wstrb;
  assign o_m_addr    = (w_grant == SRC_DATA) ? i_data_addr    : i_inst_addr;
  assign o_m_wdata   = (w_grant == SRC_DATA) ? i_data_wdata   : i_inst_wdata;
  assign o_m_uncache = (w_grant == SRC_DATA) ? i_data_uncache : i_inst_uncache;

  assign o_inst_addr_ok = w_push & (w_grant == SRC_INST);
  assign o_data_addr_ok = w_push & (w_grant == SRC_DATA);
  assign o_inst_data_ok = w_pop & (w_head == SRC_INST);
  assign o_data_data_ok = w_pop & (w_head == SRC_DATA);
  assign o_inst_rdata   = i_m_rdata;
  assign o_data_rdata   = i_m_rdata;

  assign o_outst_cnt    = i_rst ? '0 : w_cnt;
  assign o_err_spurious = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock     <= 1'b0;
      r_lock_src <= SRC_INST;
      r_err      <= 1'b0;
    end else begin
      if (o_m_req && !i_m_addr_ok) begin
        r_lock     <= 1'b1;
        r_lock_src <= w_grant;
      end else if (o_m_req) begin
        r_lock <= 1'b0;
      end
      if (i_m_data_ok && w_empty) r_err <= 1'b1;
    end
  end

  arb_src_fifo #(
    .Depth(MAX_OUTST)
  ) u_src_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_push),
    .i_din  (w_grant),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_cnt  (w_cnt),
    .o_full (w_full),
    .o_empty(w_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: grant, lock, in-order routing, full, reset and spurious responses.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_uncache;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr, data_uncache;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr, m_uncache;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic [2:0]  outst_cnt;
  logic        err_spurious;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_req_arbiter dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_inst_req    (inst_req),
    .i_inst_wr     (inst_wr),
    .i_inst_size   (inst_size),
    .i_inst_wstrb  (inst_wstrb),
    .i_inst_addr   (inst_addr),
    .i_inst_wdata  (inst_wdata),
    .i_inst_uncache(inst_uncache),
    .o_inst_addr_ok(inst_addr_ok),
    .o_inst_data_ok(inst_data_ok),
    .o_inst_rdata  (inst_rdata),
    .i_data_req    (data_req),
    .i_data_wr     (data_wr),
    .i_data_size   (data_size),
    .i_data_wstrb  (data_wstrb),
    .i_data_addr   (data_addr),
    .i_data_wdata  (data_wdata),
    .i_data_uncache(data_uncache),
    .o_data_addr_ok(data_addr_ok),
    .o_data_data_ok(data_data_ok),
    .o_data_rdata  (data_rdata),
    .o_m_req       (m_req),
    .o_m_wr        (m_wr),
    .o_m_size      (m_size),
    .o_m_wstrb     (m_wstrb),
    .o_m_addr      (m_addr),
    .o_m_wdata     (m_wdata),
    .o_m_uncache   (m_uncache),
    .i_m_addr_ok   (m_addr_ok),
    .i_m_data_ok   (m_data_ok),
    .i_m_rdata     (m_rdata),
    .o_outst_cnt   (outst_cnt),
    .o_err_spurious(err_spurious)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one accepted request from a single source (0=inst, 1=data).
  task automatic issue(input logic src);
    inst_req  = ~src;
    data_req  = src;
    m_addr_ok = 1'b1;
    #1;
    chk(src ? "iss_data_addr_ok" : "iss_inst_addr_ok", src ? data_addr_ok : inst_addr_ok, 1);
    tick();
    inst_req  = 1'b0;
    data_req  = 1'b0;
    m_addr_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0;
    inst_addr = 32'h1C00_0000; inst_wdata = 32'h0; inst_uncache = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h8000_1000; data_wdata = 32'h0; data_uncache = 1'b1;
    m_addr_ok = 1'b1; m_data_ok = 1'b0; m_rdata = 32'h0;
    tick(); tick();
    chk("rst_m_req", m_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_cnt", outst_cnt, 0);
    chk("rst_err", err_spurious, 0);

    // 1: inst-only read, response three cycles later
    rst = 1'b0;
    #1;
    chk("t1_m_req", m_req, 1);
    chk("t1_m_addr", m_addr, 32'h1C00_0000);
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    #1;
    chk("t1_cnt1", outst_cnt, 1);
    tick(); tick();
    m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_data_data_ok", data_data_ok, 0);
    chk("t1_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
    chk("t1_data_rdata", data_rdata, 32'hDEAD_BEEF);
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("t1_cnt0", outst_cnt, 0);

    // 2: simultaneous requests, data wins the first tie
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wdata = 32'h1234_5678;
    data_wstrb = 4'hF; m_addr_ok = 1'b1;
    #1;
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok", inst_addr_ok, 0);
    chk("t2_m_addr", m_addr, 32'h8000_1000);
    chk("t2_m_wr", m_wr, 1);
    chk("t2_m_wdata", m_wdata, 32'h1234_5678);
    chk("t2_m_uncache", m_uncache, 1);
    tick();
    chk("t2_cnt1", outst_cnt, 1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t2_second_inst", inst_addr_ok, 1);
    chk("t2_second_data", data_addr_ok, 0);
`else
    chk("t2_second_inst", inst_addr_ok, 0);
    chk("t2_second_data", data_addr_ok, 1);
`endif
    tick();
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; data_wr = 1'b0;
    #1;
    chk("t2_cnt2", outst_cnt, 2);
    m_data_ok = 1'b1;
    #1;
    chk("t2_pop1_data", data_data_ok, 1);
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("t2_pop2_inst", inst_data_ok, 1);
`else
    chk("t2_pop2_data", data_data_ok, 1);
`endif
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("t2_cnt0", outst_cnt, 0);

    // 3: data handshake stalled three cycles while inst also requests
    inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h8000_2000; m_addr_ok = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t3_m_addr_hold", m_addr, 32'h8000_2000);
      chk("t3_no_inst_ok", inst_addr_ok, 0);
      tick();
    end
    m_addr_ok = 1'b1;
    #1;
    chk("t3_m_addr_acc", m_addr, 32'h8000_2000);
    chk("t3_data_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 1'b0; m_addr_ok = 1'b0;
    #1;
    chk("t3_cnt1", outst_cnt, 1);
    // 3b: inst holds the lock when data joins mid-handshake
    chk("t3b_m_addr_inst", m_addr, 32'h1C00_0000);
    tick();
    data_req = 1'b1;
    #1;
    chk("t3b_lock_addr", m_addr, 32'h1C00_0000);
    chk("t3b_lock_req", m_req, 1);
    tick();
    m_addr_ok = 1'b1;
    #1;
    chk("t3b_inst_addr_ok", inst_addr_ok, 1);
    chk("t3b_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
    #1;
    chk("t3b_cnt2", outst_cnt, 2);
    m_data_ok = 1'b1;
    #1;
    chk("t3b_pop_data", data_data_ok, 1);
    tick();
    chk("t3b_pop_inst", inst_data_ok, 1);
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("t3b_cnt0", outst_cnt, 0);

    // 4: fill to MAX_OUTST with I,D,D,I, then pop with a pending request
    issue(1'b0); issue(1'b1); issue(1'b1); issue(1'b0);
    #1;
    chk("t4_cnt4", outst_cnt, 4);
    inst_req = 1'b1; m_addr_ok = 1'b1;
    #1;
    chk("t4_full_m_req", m_req, 0);
    chk("t4_full_addr_ok", inst_addr_ok, 0);
    m_data_ok = 1'b1;
    #1;
    chk("t4_pop1_inst", inst_data_ok, 1);
    chk("t4_pop1_no_issue", inst_addr_ok, 0);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    #1;
    chk("t4_cnt3", outst_cnt, 3);
    chk("t4_pop2_data", data_data_ok, 1);
    tick();
    chk("t4_pop3_data", data_data_ok, 1);
    tick();
    chk("t4_pop4_inst", inst_data_ok, 1);
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("t4_cnt0", outst_cnt, 0);

    // 5: push and pop in the same cycle at count 2
    issue(1'b1); issue(1'b0);
    data_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
    #1;
    chk("t5_data_addr_ok", data_addr_ok, 1);
    chk("t5_pop_data", data_data_ok, 1);
    chk("t5_pop_no_inst", inst_data_ok, 0);
    tick();
    data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    #1;
    chk("t5_cnt2", outst_cnt, 2);
    m_data_ok = 1'b1;
    #1;
    chk("t5_pop_inst", inst_data_ok, 1);
    tick();
    chk("t5_pop_data2", data_data_ok, 1);
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("t5_cnt0", outst_cnt, 0);
    chk("t5_err_clear", err_spurious, 0);

    // 6: reset with 3 outstanding, then a stale response
    issue(1'b0); issue(1'b1); issue(1'b0);
    #1;
    chk("t6_cnt3", outst_cnt, 3);
    rst = 1'b1; inst_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
    #1;
    chk("t6_rst_cnt", outst_cnt, 0);
    chk("t6_rst_m_req", m_req, 0);
    chk("t6_rst_addr_ok", inst_addr_ok, 0);
    chk("t6_rst_data_ok", inst_data_ok, 0);
    tick();
    rst = 1'b0; inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    #1;
    chk("t6_err_before", err_spurious, 0);
    chk("t6_stale_inst_ok", inst_data_ok, 0);
    chk("t6_stale_data_ok", data_data_ok, 0);
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("t6_err_set", err_spurious, 1);
    chk("t6_cnt0", outst_cnt, 0);
    tick();
    chk("t6_err_sticky", err_spurious, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
